// File: rtl/control_cuadrantes.sv
// control_cuadrantes: quadrant selection, processor launch/wait sequencing and
// pixel-memory address generation for the 400x400 image window.
//
// Handshake: proc_go is a one-cycle request pulse. The processing core may
// assert proc_done (level or pulse) any time afterwards. The controller samples
// proc_done only while waiting. Each raw button is synchronised and turned into
// a single rising-edge event.
`timescale 1ns/1ps
module control_cuadrantes #(
  parameter int          IMG_X0    = 20,
  parameter int          IMG_Y0    = 40,
  parameter int          IMG_W     = 400,
  parameter int          ADDR_W    = 18,
  parameter int          DRAM_BASE = 0,
  parameter int          LOOKAHEAD = 1,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_start,
  input  logic              proc_done,
  output logic [4:0]        quadrant,
  output logic              start,
  output logic              proc_go,
  output logic              busy,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] drom_addr,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {SELECT, LAUNCH, WAIT_PROC, SHOW} state_t;

  state_t      state, state_nx;
  logic [4:0]  quad_nx;
  logic [23:0] cnt, cnt_nx;
  logic        err_nx;
  logic [2:0]  next_sh, prev_sh, start_sh;
  logic        next_ev, prev_ev, start_ev;

  // Addresses advance every clock; pixel_tick ratio is absorbed by LOOKAHEAD.
  logic unused_pixel_tick;
  assign unused_pixel_tick = pixel_tick;

  assign dbg_state = state;

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_sh  <= '0;
      prev_sh  <= '0;
      start_sh <= '0;
    end else begin
      next_sh  <= {next_sh[1:0], btn_next};
      prev_sh  <= {prev_sh[1:0], btn_prev};
      start_sh <= {start_sh[1:0], btn_start};
    end
  end

  assign next_ev  = next_sh[1] & ~next_sh[2];
  assign prev_ev  = prev_sh[1] & ~prev_sh[2];
  assign start_ev = start_sh[1] & ~start_sh[2];

  // Next-state, quadrant and timeout bookkeeping.
  always_comb begin
    state_nx = state;
    quad_nx  = quadrant;
    cnt_nx   = cnt;
    err_nx   = timeout_err;
    case (state)
      SELECT: begin
        if (start_ev) begin
          state_nx = LAUNCH;
        end else if (next_ev && !prev_ev) begin
          quad_nx = (quadrant == 5'd16) ? 5'd1 : quadrant + 5'd1;
        end else if (prev_ev && !next_ev) begin
          quad_nx = (quadrant == 5'd1) ? 5'd16 : quadrant - 5'd1;
        end
      end
      LAUNCH: begin
        state_nx = WAIT_PROC;
        cnt_nx   = '0;
      end
      WAIT_PROC: begin
        // proc_done beats a timeout landing on the same cycle.
        if (proc_done) begin
          state_nx = SHOW;
        end else if (cnt == TIMEOUT - 24'd1) begin
          state_nx = SELECT;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      SHOW: begin
        if (start_ev) begin
          state_nx = SELECT;
          err_nx   = 1'b0;
        end
      end
      default: state_nx = SELECT;
    endcase
  end

  // State register; status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SELECT;
      quadrant    <= 5'd1;
      cnt         <= '0;
      timeout_err <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      proc_go     <= 1'b0;
    end else begin
      state       <= state_nx;
      quadrant    <= quad_nx;
      cnt         <= cnt_nx;
      timeout_err <= err_nx;
      start       <= (state_nx == SHOW);
      busy        <= (state_nx == LAUNCH) || (state_nx == WAIT_PROC);
      proc_go     <= (state_nx == LAUNCH);
    end
  end

  logic [10:0]       xa;
  logic              win_act;
  logic [ADDR_W-1:0] row_off, col_off, pix_off;

  // Window test and linear pixel offset for the look-ahead column.
  always_comb begin
    xa      = {1'b0, x} + 11'(LOOKAHEAD);
    win_act = (xa >= 11'(IMG_X0)) && (xa <= 11'(IMG_X0 + IMG_W - 1)) &&
              (y >= 10'(IMG_Y0)) && (y <= 10'(IMG_Y0 + IMG_W - 1));
    row_off = ADDR_W'(y) - ADDR_W'(IMG_Y0);
    col_off = ADDR_W'(xa) - ADDR_W'(IMG_X0);
    pix_off = row_off * ADDR_W'(IMG_W) + col_off;
  end

  // Address registers; outside the window both memories see address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drom_addr <= '0;
      dram_addr <= '0;
    end else if (win_act) begin
      drom_addr <= pix_off;
      dram_addr <= pix_off + ADDR_W'(DRAM_BASE);
    end else begin
      drom_addr <= '0;
      dram_addr <= '0;
    end
  end

endmodule

// File: tb/tb_control_cuadrantes.sv
// Directed bench for control_cuadrantes: buttons, launch handshake, timeout,
// window addressing and asynchronous reset.
`timescale 1ns/1ps
module tb_control_cuadrantes;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pixel_tick = 1'b1;
  logic [9:0]        x = '0;
  logic [9:0]        y = '0;
  logic              btn_next = 1'b0;
  logic              btn_prev = 1'b0;
  logic              btn_start = 1'b0;
  logic              proc_done = 1'b0;
  logic [4:0]        quadrant;
  logic              start;
  logic              proc_go;
  logic              busy;
  logic              timeout_err;
  logic [ADDR_W-1:0] drom_addr;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  control_cuadrantes #(
    .IMG_X0(20), .IMG_Y0(40), .IMG_W(400), .ADDR_W(ADDR_W),
    .DRAM_BASE(1000), .LOOKAHEAD(1), .TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .x(x), .y(y),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_start(btn_start),
    .proc_done(proc_done), .quadrant(quadrant), .start(start),
    .proc_go(proc_go), .busy(busy), .timeout_err(timeout_err),
    .drom_addr(drom_addr), .dram_addr(dram_addr), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // which: 0 next, 1 prev, 2 start, 3 next+prev together
  task automatic press(input int which, input int hold);
    case (which)
      0: btn_next = 1'b1;
      1: btn_prev = 1'b1;
      2: btn_start = 1'b1;
      default: begin btn_next = 1'b1; btn_prev = 1'b1; end
    endcase
    tick(hold);
    btn_next = 1'b0; btn_prev = 1'b0; btn_start = 1'b0;
    tick(4);
  endtask

  int ax[7] = '{19, 418, 19, 418, 419, 100, 18};
  int ay[7] = '{40, 40, 41, 439, 40, 39, 40};
  int ed[7] = '{0, 399, 400, 159999, 0, 0, 0};
  int er[7] = '{1000, 1399, 1400, 160999, 0, 0, 0};

  int go_cnt, busy_at_go, bcnt;

  initial begin
    // Reset state
    tick(3);
    chk("rst_quadrant", 32'(quadrant), 1);
    chk("rst_start", 32'(start), 0);
    chk("rst_proc_go", 32'(proc_go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_drom_addr", 32'(drom_addr), 0);
    chk("rst_dram_addr", 32'(dram_addr), 0);
    chk("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    tick(2);

    // Quadrant stepping and wrap
    press(0, 4); chk("next_1", 32'(quadrant), 2);
    press(0, 4); chk("next_2", 32'(quadrant), 3);
    press(0, 4); chk("next_3", 32'(quadrant), 4);
    press(1, 4); chk("prev_1", 32'(quadrant), 3);
    press(1, 4); chk("prev_2", 32'(quadrant), 2);
    press(1, 4); chk("prev_3", 32'(quadrant), 1);
    press(1, 4); chk("prev_wrap", 32'(quadrant), 16);
    press(0, 4); chk("next_wrap", 32'(quadrant), 1);
    press(3, 4); chk("next_prev_same", 32'(quadrant), 1);
    press(0, 1000); chk("hold_next", 32'(quadrant), 2);
    repeat (5) press(0, 4);
    chk("reach_7", 32'(quadrant), 7);

    // Launch handshake
    btn_start = 1'b1;
    go_cnt = 0; busy_at_go = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (i == 4) btn_start = 1'b0;
      if (proc_go) begin go_cnt++; busy_at_go = int'(busy); end
    end
    chk("proc_go_pulses", 32'(go_cnt), 1);
    chk("busy_with_go", 32'(busy_at_go), 1);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_state", 32'(dbg_state), 2);
    press(0, 4);
    press(1, 4);
    chk("wait_quadrant_held", 32'(quadrant), 7);
    chk("wait_start", 32'(start), 0);
    tick(20);
    proc_done = 1'b1; tick(1); proc_done = 1'b0; tick(1);
    chk("show_start", 32'(start), 1);
    chk("show_busy", 32'(busy), 0);
    chk("show_err", 32'(timeout_err), 0);
    chk("show_state", 32'(dbg_state), 3);
    press(0, 4);
    chk("show_quadrant_held", 32'(quadrant), 7);
    press(2, 4);
    chk("back_start", 32'(start), 0);
    chk("back_state", 32'(dbg_state), 0);
    chk("back_quadrant", 32'(quadrant), 7);

    // Timeout: LAUNCH cycle plus 100 WAIT_PROC cycles of busy
    btn_start = 1'b1; bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i == 4) btn_start = 1'b0;
      if (busy) bcnt++;
      else if (bcnt > 0) break;
    end
    chk("timeout_busy_cycles", 32'(bcnt), 101);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_err_set", 32'(timeout_err), 1);
    chk("timeout_start", 32'(start), 0);
    chk("timeout_state", 32'(dbg_state), 0);
    press(2, 4);
    chk("err_kept_wait", 32'(timeout_err), 1);
    chk("relaunch_busy", 32'(busy), 1);
    proc_done = 1'b1; tick(1); proc_done = 1'b0; tick(1);
    chk("err_kept_show", 32'(timeout_err), 1);
    chk("relaunch_show", 32'(start), 1);
    press(2, 4);
    chk("err_cleared", 32'(timeout_err), 0);
    chk("err_cleared_start", 32'(start), 0);

    // proc_done on the timeout cycle wins
    btn_start = 1'b1; bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i == 4) btn_start = 1'b0;
      if (busy) begin
        bcnt++;
        if (bcnt == 101) begin
          proc_done = 1'b1; tick(1); proc_done = 1'b0;
          break;
        end
      end
    end
    chk("tie_start", 32'(start), 1);
    chk("tie_state", 32'(dbg_state), 3);
    chk("tie_err", 32'(timeout_err), 0);
    press(2, 4);
    chk("tie_back", 32'(dbg_state), 0);

    // Window addressing
    for (int i = 0; i < 7; i++) begin
      x = 10'(ax[i]); y = 10'(ay[i]);
      tick(1);
      chk($sformatf("drom_%0d_%0d", ax[i], ay[i]), 32'(drom_addr), 32'(ed[i]));
      chk($sformatf("dram_%0d_%0d", ax[i], ay[i]), 32'(dram_addr), 32'(er[i]));
    end

    // Asynchronous reset while waiting on the processor
    press(0, 4);
    chk("pre_reset_quadrant", 32'(quadrant), 8);
    press(2, 4);
    chk("pre_reset_state", 32'(dbg_state), 2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_quadrant", 32'(quadrant), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_start", 32'(start), 0);
    chk("async_proc_go", 32'(proc_go), 0);
    chk("async_state", 32'(dbg_state), 0);
    chk("async_drom", 32'(drom_addr), 0);
    @(negedge clk);
    reset = 1'b1;
    proc_done = 1'b1; tick(3); proc_done = 1'b0; tick(2);
    chk("late_done_state", 32'(dbg_state), 0);
    chk("late_done_start", 32'(start), 0);
    chk("late_done_busy", 32'(busy), 0);
    chk("late_done_quadrant", 32'(quadrant), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
